hansen_fetch_buffer: RTL and testbench

//   Instruction fetch stage upstream of the hansen_core decode. Generates sequential fetch

---
 rtl/hansen_fetch_buffer_if.sv | 30 +++
 rtl/hansen_fetch_buffer.sv | 105 ++++++++++
 tb/tb_hansen_fetch_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hansen_fetch_buffer_if.sv
// Fetch-buffer signal bundle: redirect input, instruction-memory request/response, decode-side
// valid/ready queue head and occupancy.
interface hansen_fetch_buffer_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          imem_req_valid;
    logic [31:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    // master: the fetch buffer itself; slave: execute/memory/decode environment.
    modport master (
        input  redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/hansen_fetch_buffer.sv
// Sequential instruction fetch into a DEPTH-entry {pc, instr} FIFO with credit-based request
// throttling and redirect flush of the queue and any in-flight fetch.
module hansen_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   reset,
    hansen_fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          out_valid;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW:0]   credit;
    logic [31:0]   redirect_target;

    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = bus.imem_rsp_valid && inflight_q && !kill_q;

    // Entries already held or still arriving, minus the one leaving this cycle; subtracting
    // pop lets a full queue keep streaming at one instruction per cycle.
    assign credit = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign issue  = !reset && !bus.redirect_valid && (credit < (CW + 1)'(DEPTH));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        kill_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_target;
            kill_d     = inflight_q;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !bus.redirect_valid) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = issue;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = out_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign bus.out_instr      = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_hansen_fetch_buffer.sv
// Directed bench for hansen_fetch_buffer: DEPTH=4 instance for streaming/stall/redirect/reset,
// DEPTH=2 instance for redirect against a full queue. Memory returns ~addr as the instruction.
module tb_hansen_fetch_buffer;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];

    hansen_fetch_buffer_if #(.DEPTH(4)) a_if ();
    hansen_fetch_buffer_if #(.DEPTH(2)) b_if ();

    hansen_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if.master)
    );

    hansen_fetch_buffer #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.master)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memories.
    always @(posedge clk) begin
        a_if.imem_rsp_valid <= a_if.imem_req_valid;
        a_if.imem_rsp_data  <= ~a_if.imem_req_addr;
        b_if.imem_rsp_valid <= b_if.imem_req_valid;
        b_if.imem_rsp_data  <= ~b_if.imem_req_addr;
    end

    // Monitors: every accepted head (outside reset/redirect cycles) is matched in order.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!rst_a && !a_if.redirect_valid && a_if.out_valid && a_if.out_ready) begin
            total++;
            if (sb_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected: got pc=%h instr=%h, required no output",
                         a_if.out_pc, a_if.out_instr);
            end else begin
                exp = sb_a.pop_front();
                if (a_if.out_pc !== exp || a_if.out_instr !== ~exp) begin
                    bad++;
                    $display("FAIL a_head: got pc=%h instr=%h, required pc=%h instr=%h",
                             a_if.out_pc, a_if.out_instr, exp, ~exp);
                end
            end
        end
        if (!rst_b && !b_if.redirect_valid && b_if.out_valid && b_if.out_ready) begin
            total++;
            if (sb_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: got pc=%h instr=%h, required no output",
                         b_if.out_pc, b_if.out_instr);
            end else begin
                exp = sb_b.pop_front();
                if (b_if.out_pc !== exp || b_if.out_instr !== ~exp) begin
                    bad++;
                    $display("FAIL b_head: got pc=%h instr=%h, required pc=%h instr=%h",
                             b_if.out_pc, b_if.out_instr, exp, ~exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Two reset edges; returns at the start of cycle 0 (first cycle with reset low).
    task automatic reset_a(input logic rdy);
        rst_a = 1'b1;
        a_if.redirect_valid = 1'b0;
        a_if.out_ready = 1'b0;
        cyc();
        mid();
        chk("rst_out_valid", a_if.out_valid, 1'b0);
        chk("rst_req_valid", a_if.imem_req_valid, 1'b0);
        chk("rst_req_addr", a_if.imem_req_addr, 32'h0);
        chk("rst_out_pc", a_if.out_pc, 32'h0);
        chk("rst_out_instr", a_if.out_instr, 32'h0);
        chk("rst_count", a_if.count, 32'h0);
        cyc();
        rst_a = 1'b0;
        a_if.out_ready = rdy;
    endtask

    initial begin
        int nreq;
        a_if.redirect_valid = 1'b0;
        a_if.redirect_pc = 32'h0;
        a_if.out_ready = 1'b0;
        b_if.redirect_valid = 1'b0;
        b_if.redirect_pc = 32'h0;
        b_if.out_ready = 1'b0;

        // 1: streaming, 3*DEPTH entries, one per cycle from cycle 2
        reset_a(1'b1);
        for (int i = 0; i < 12; i++) sb_a.push_back(32'(4 * i));
        mid();
        chk("t1_req_valid_c0", a_if.imem_req_valid, 1'b1);
        chk("t1_req_addr_c0", a_if.imem_req_addr, 32'h0);
        chk("t1_out_valid_c0", a_if.out_valid, 1'b0);
        cyc();
        cyc();
        mid();
        chk("t1_out_valid_c2", a_if.out_valid, 1'b1);
        chk("t1_out_pc_c2", a_if.out_pc, 32'h0);
        repeat (11) cyc();
        cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t1_drained", sb_a.size(), 0);

        // 2: stalled decode fills the queue, then drains in order
        reset_a(1'b0);
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            mid();
            if (a_if.imem_req_valid) begin
                chk("t2_req_addr", a_if.imem_req_addr, 32'(4 * nreq));
                nreq++;
            end
            if (c == 7) begin
                chk("t2_count_full", a_if.count, 32'd4);
                chk("t2_req_stalled", a_if.imem_req_valid, 1'b0);
                chk("t2_head_stable", a_if.out_pc, 32'h0);
            end
            cyc();
        end
        chk("t2_nreq", nreq, 4);
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        sb_a.push_back(32'h8);
        sb_a.push_back(32'hC);
        sb_a.push_back(32'h10);
        a_if.out_ready = 1'b1;
        repeat (5) cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t2_drained", sb_a.size(), 0);

        // 3: single redirect while streaming
        reset_a(1'b1);
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        sb_a.push_back(32'h8);
        sb_a.push_back(32'hC);
        sb_a.push_back(32'h100);
        sb_a.push_back(32'h104);
        repeat (6) cyc();
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 32'h100;
        mid();
        chk("t3_no_req_T", a_if.imem_req_valid, 1'b0);
        cyc();
        a_if.redirect_valid = 1'b0;
        mid();
        chk("t3_count_T1", a_if.count, 32'h0);
        chk("t3_out_valid_T1", a_if.out_valid, 1'b0);
        chk("t3_req_valid_T1", a_if.imem_req_valid, 1'b1);
        chk("t3_req_addr_T1", a_if.imem_req_addr, 32'h100);
        cyc();
        mid();
        chk("t3_count_T2", a_if.count, 32'h0);
        cyc();
        mid();
        chk("t3_out_valid_T3", a_if.out_valid, 1'b1);
        chk("t3_out_pc_T3", a_if.out_pc, 32'h100);
        cyc();
        cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t3_drained", sb_a.size(), 0);

        // 4: back-to-back redirects, last one wins, low pc bits dropped
        reset_a(1'b1);
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        sb_a.push_back(32'h8);
        sb_a.push_back(32'hC);
        sb_a.push_back(32'h200);
        sb_a.push_back(32'h204);
        repeat (6) cyc();
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 32'h100;
        cyc();
        a_if.redirect_pc = 32'h203;
        mid();
        chk("t4_no_req_T1", a_if.imem_req_valid, 1'b0);
        cyc();
        a_if.redirect_valid = 1'b0;
        mid();
        chk("t4_req_addr_T2", a_if.imem_req_addr, 32'h200);
        chk("t4_out_valid_T2", a_if.out_valid, 1'b0);
        cyc();
        mid();
        chk("t4_out_valid_T3", a_if.out_valid, 1'b0);
        cyc();
        mid();
        chk("t4_out_pc_T4", a_if.out_pc, 32'h200);
        cyc();
        cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t4_drained", sb_a.size(), 0);

        // 7: fetch address wraps past 0xFFFFFFFC
        reset_a(1'b1);
        a_if.redirect_valid = 1'b1;
        a_if.redirect_pc = 32'hFFFF_FFFB;
        sb_a.push_back(32'hFFFF_FFF8);
        sb_a.push_back(32'hFFFF_FFFC);
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        cyc();
        a_if.redirect_valid = 1'b0;
        mid();
        chk("t7_req_addr", a_if.imem_req_addr, 32'hFFFF_FFF8);
        repeat (6) cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t7_drained", sb_a.size(), 0);

        // 6: one-cycle reset mid-stream with a fetch in flight
        reset_a(1'b1);
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        sb_a.push_back(32'h8);
        sb_a.push_back(32'hC);
        repeat (6) cyc();
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        sb_a.push_back(32'h0);
        sb_a.push_back(32'h4);
        mid();
        chk("t6_out_valid", a_if.out_valid, 1'b0);
        chk("t6_req_addr", a_if.imem_req_addr, 32'h0);
        chk("t6_req_valid", a_if.imem_req_valid, 1'b1);
        chk("t6_count", a_if.count, 32'h0);
        cyc();
        mid();
        chk("t6_out_valid_r1", a_if.out_valid, 1'b0);
        cyc();
        mid();
        chk("t6_out_valid_r2", a_if.out_valid, 1'b1);
        chk("t6_out_pc_r2", a_if.out_pc, 32'h0);
        cyc();
        cyc();
        a_if.out_ready = 1'b0;
        mid();
        chk("t6_drained", sb_a.size(), 0);

        // 5: DEPTH=2, redirect coinciding with push and pop right after the queue was full
        cyc();
        mid();
        chk("t5_rst_count", b_if.count, 32'h0);
        chk("t5_rst_out_valid", b_if.out_valid, 1'b0);
        cyc();
        rst_b = 1'b0;
        sb_b.push_back(32'h0);
        sb_b.push_back(32'h40);
        sb_b.push_back(32'h44);
        sb_b.push_back(32'h48);
        sb_b.push_back(32'h4C);
        repeat (3) cyc();
        mid();
        chk("t5_full", b_if.count, 32'd2);
        chk("t5_full_no_req", b_if.imem_req_valid, 1'b0);
        cyc();
        b_if.out_ready = 1'b1;
        mid();
        chk("t5_req_on_pop", b_if.imem_req_valid, 1'b1);
        cyc();
        b_if.redirect_valid = 1'b1;
        b_if.redirect_pc = 32'h40;
        mid();
        chk("t5_count_pre", b_if.count, 32'd1);
        chk("t5_rsp_pending", b_if.imem_rsp_valid, 1'b1);
        cyc();
        b_if.redirect_valid = 1'b0;
        mid();
        chk("t5_count_cleared", b_if.count, 32'h0);
        chk("t5_out_valid_cleared", b_if.out_valid, 1'b0);
        chk("t5_req_addr", b_if.imem_req_addr, 32'h40);
        cyc();
        cyc();
        mid();
        chk("t5_out_pc", b_if.out_pc, 32'h40);
        repeat (4) cyc();
        b_if.out_ready = 1'b0;
        mid();
        chk("t5_drained", sb_b.size(), 0);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
